// File: rtl/flit_packetizer_sub.sv
// Packetizes one wide payload word (plus dst/vc) into NUM_FLITS NoC flits,
// emitted one per cycle over a valid/ready link.
module flit_packetizer_sub #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_OUT        = 36,
  parameter int NUM_FLITS        = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic                        valid_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  output logic                        ready_out,
  output logic [WIDTH_OUT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in
);
  localparam int PH  = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int PB  = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
  localparam int CAP = PH + (NUM_FLITS - 1) * PB;
  localparam int IW  = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

  if (WIDTH_IN > CAP) begin : g_width_chk
    $fatal(1, "flit_packetizer_sub: WIDTH_IN %0d exceeds packet payload capacity %0d", WIDTH_IN, CAP);
  end

  typedef struct packed {
    logic [WIDTH_IN-1:0]         data;
    logic [ADDRESS_WIDTH-1:0]    dst;
    logic [VC_ADDRESS_WIDTH-1:0] vc;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t  state, state_n;
  logic [IW-1:0] idx, idx_n;
  req_t    cap, cap_n;
  logic    last, accept, xfer;

  logic [CAP-1:0]                 padded;
  logic [NUM_FLITS-1:0][PB-1:0]   pay;
  logic [PB-1:0]                  sel;

  assign last      = (idx == IW'(NUM_FLITS - 1));
  assign valid_out = (state == BUSY);
  assign ready_out = rst & ((state == IDLE) | (last & ready_in));
  assign accept    = valid_in & ready_out;
  assign xfer      = valid_out & ready_in;

  // Zero-extend the captured word to the full packet capacity, then cut one
  // payload slice per flit; flit 0 has a shorter slice because it carries dst.
  assign padded = CAP'(cap.data);

  for (genvar k = 0; k < NUM_FLITS; k++) begin : g_slice
    if (k == 0) begin : g_head
      assign pay[k] = PB'(padded[PH-1:0]);
    end else begin : g_body
      assign pay[k] = padded[PH + (k - 1) * PB +: PB];
    end
  end

  if (NUM_FLITS == 1) begin : g_sel1
    assign sel = pay[0];
  end else begin : g_seln
    assign sel = pay[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      cap   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cap   <= cap_n;
    end
  end

  // A new word can only be accepted while idle or while the last flit leaves,
  // so accept takes priority over the end-of-packet return to idle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cap_n   = cap;
    if (accept) begin
      cap_n.data = data_in;
      cap_n.dst  = dst_in;
      cap_n.vc   = vc_in;
      idx_n      = '0;
      state_n    = BUSY;
    end else if (xfer) begin
      if (last) begin
        state_n = IDLE;
        idx_n   = '0;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (state == BUSY) begin
      data_out[WIDTH_OUT-1] = 1'b1;
      data_out[WIDTH_OUT-2] = (idx == '0);
      data_out[WIDTH_OUT-3] = last;
      data_out[WIDTH_OUT-4 -: VC_ADDRESS_WIDTH] = cap.vc;
      if (idx == '0) begin
        data_out[WIDTH_OUT-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH] = cap.dst;
        data_out[PH-1:0] = sel[PH-1:0];
      end else begin
        data_out[PB-1:0] = sel;
      end
    end
  end

endmodule

// File: tb/tb_flit_packetizer_sub.sv
// Drives four packetizer configurations (1..4 flits) from shared stimulus and
// compares each against a queue-of-flits reference model.
module tb_flit_packetizer_sub;
  logic                clk = 1'b0;
  logic                rst;
  logic [111:0]        dbus;
  logic                vin;
  logic [3:0]          dst;
  logic                vc;
  logic                rdy_in;
  logic [3:0]          rdy_o;
  logic [3:0]          vld_o;
  logic [3:0][35:0]    dat_o;

  int checks = 0;
  int errors = 0;
  logic [35:0] mq [4][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WIN = (g == 0) ? 12 : (g == 1) ? 40 : (g == 2) ? 80 : 112;
    flit_packetizer_sub #(.NUM_FLITS(g + 1), .WIDTH_IN(WIN)) u_dut (
      .clk(clk), .rst(rst), .data_in(dbus[WIN-1:0]), .valid_in(vin),
      .dst_in(dst), .vc_in(vc), .ready_out(rdy_o[g]), .data_out(dat_o[g]),
      .valid_out(vld_o[g]), .ready_in(rdy_in));
  end

  function automatic logic [111:0] wmask(int g);
    int w;
    w = (g == 0) ? 12 : (g == 1) ? 40 : (g == 2) ? 80 : 112;
    return (112'd1 << w) - 112'd1;
  endfunction

  // Flit k of an nf-flit packet: 28-bit head payload, then 32-bit body chunks.
  function automatic logic [35:0] mk(int nf, logic [111:0] d, logic [3:0] ds, logic v, int k);
    logic [111:0] p;
    logic tail;
    tail = (k == nf - 1);
    if (k == 0) begin
      p = d & ((112'd1 << 28) - 112'd1);
      return {2'b11, tail, v, ds, p[27:0]};
    end
    p = (d >> (28 + (k - 1) * 32)) & ((112'd1 << 32) - 112'd1);
    return {2'b10, tail, v, p[31:0]};
  endfunction

  task automatic chk(string tag, logic [35:0] obs, logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: checks outputs, then
  // advances the model by what the next rising edge should do.
  task automatic step();
    logic [35:0] ed;
    logic ev, er;
    #1;
    for (int g = 0; g < 4; g++) begin
      ev = (mq[g].size() > 0);
      ed = ev ? mq[g][0] : 36'h0;
      er = rst && (mq[g].size() == 0 || (mq[g].size() == 1 && rdy_in));
      chk($sformatf("nf%0d_valid", g + 1), 36'(vld_o[g]), 36'(ev));
      chk($sformatf("nf%0d_data", g + 1), dat_o[g], ed);
      chk($sformatf("nf%0d_ready", g + 1), 36'(rdy_o[g]), 36'(er));
      if (!rst) mq[g].delete();
      else begin
        if (ev && rdy_in) void'(mq[g].pop_front());
        if (vin && er)
          for (int k = 0; k <= g; k++) mq[g].push_back(mk(g + 1, dbus & wmask(g), dst, vc, k));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic r, logic v, logic ri, logic [111:0] d, logic [3:0] ds, logic c);
    rst = r; vin = v; rdy_in = ri; dbus = d; dst = ds; vc = c;
    step();
  endtask

  initial begin
    rst = 1'b0; vin = 1'b0; rdy_in = 1'b0; dbus = '0; dst = '0; vc = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 112'hFFF, 4'hF, 1'b1);
    drive(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);

    // Two-flit split of a 40-bit word
    drive(1'b1, 1'b1, 1'b1, 112'h123456789A, 4'd3, 1'b0);
    chk("nf2_head_literal", dat_o[1], 36'hC3456789A);
    chk("nf1_single_literal", dat_o[0], 36'hE3000089A);
    drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    chk("nf2_tail_literal", dat_o[1], 36'hA00000123);
    drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    chk("nf2_drop_literal", 36'(vld_o[1]), 36'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);

    // Single-flit packet
    drive(1'b1, 1'b1, 1'b1, 112'hABC, 4'd5, 1'b1);
    rdy_in = 1'b1; vin = 1'b0;
    #1;
    chk("nf1_flit_literal", dat_o[0], 36'hF50000ABC);
    chk("nf1_ready_literal", 36'(rdy_o[0]), 36'h1);
    drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);

    // Stall: head held, valid_in ignored while busy
    drive(1'b1, 1'b1, 1'b1, 112'h5A5A_0F0F_3C3C_1234_5678_9ABC_DEF0, 4'd9, 1'b1);
    for (int i = 0; i < 4; i++)
      drive(1'b0 | 1'b1, 1'b1, 1'b0, {$urandom(), $urandom(), $urandom(), 16'h0}, 4'($urandom()), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);

    // Back-to-back packets with continuous valid and ready
    for (int i = 0; i < 24; i++)
      drive(1'b1, 1'b1, 1'b1, 112'({$urandom(), $urandom(), $urandom(), $urandom()}), 4'($urandom()), 1'($urandom()));
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);

    // Reset in the middle of a packet
    drive(1'b1, 1'b1, 1'b1, 112'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468, 4'd6, 1'b1);
    drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 112'h77, 4'd1, 1'b0);
    chk("rst_valid_literal", 36'(vld_o[2]), 36'h0);
    chk("rst_data_literal", dat_o[2], 36'h0);
    drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);

    // Random traffic with back-pressure and occasional resets
    for (int i = 0; i < 600; i++)
      drive(1'(($urandom() % 60) != 0), 1'(($urandom() % 4) != 0), 1'(($urandom() % 4) != 0),
            112'({$urandom(), $urandom(), $urandom(), $urandom()}), 4'($urandom()), 1'($urandom()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
